// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and constants for the host-side CPU run controller.
// The phase-skip helper keeps the load/run/drain ordering in one place.
package cpu_run_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD_I,
      S_LOAD_D,
      S_REL,
      S_RUN,
      S_DRAIN_RD,
      S_DRAIN_WAIT,
      S_DRAIN_OUT,
      S_DONE
   } state_e;

   localparam int unsigned IMEM_STRIDE = 4;
   localparam int unsigned DMEM_STRIDE = 8;

   localparam state_e      RST_STATE  = S_IDLE;
   localparam logic        RST_ARST_N = 1'b0;
   localparam logic        RST_ENABLE = 1'b0;
   localparam logic [15:0] RST_IDX    = 16'd0;
   localparam logic [63:0] RST_DATA   = 64'd0;

   function automatic logic [15:0] clamp16(
      input logic [15:0] v,
      input int unsigned depth
   );
      return (32'(v) > depth) ? 16'(depth) : v;
   endfunction

   // First non-empty phase at or after 'from' (LOAD_I, LOAD_D, REL or DRAIN_RD).
   function automatic state_e first_phase(
      input state_e from,
      input logic   ni_nz,
      input logic   nd_nz,
      input logic   nr_nz,
      input logic   no_nz
   );
      state_e s;
      s = S_DONE;
      if (no_nz) s = S_DRAIN_RD;
      if (nr_nz && from != S_DRAIN_RD) s = S_REL;
      if (nd_nz && (from == S_LOAD_I || from == S_LOAD_D)) s = S_LOAD_D;
      if (ni_nz && from == S_LOAD_I) s = S_LOAD_I;
      return s;
   endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Host link of the run controller: configuration, start, load stream,
// drain stream and status.
interface cpu_run_ctrl_if #(
   parameter int CYC_W = 32
);
   logic             start;
   logic [15:0]      n_instr;
   logic [15:0]      n_din;
   logic [15:0]      n_dout;
   logic [CYC_W-1:0] run_cycles;
   logic             in_valid;
   logic             in_ready;
   logic [63:0]      in_data;
   logic             out_valid;
   logic             out_ready;
   logic [63:0]      out_data;
   logic             busy;
   logic             done;

   modport master (
      output start, n_instr, n_din, n_dout, run_cycles,
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, busy, done
   );

   modport slave (
      input  start, n_instr, n_din, n_dout, run_cycles,
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, busy, done
   );
endinterface

// File: rtl/cpu_run_ctrl_out_hold_reg.sv
// Valid/ready holding register for the drain stream; data stays
// stable while valid is high and ready is low.
module out_hold_reg #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   input  logic         ready_i,
   output logic         valid_o,
   output logic [W-1:0] data_o
);

   logic         valid_q;
   logic [W-1:0] data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
      end else if (valid_q && ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: loads imem/dmem from the host, runs the CPU for a
// programmed cycle count, then drains a range of dmem back to the host.
module cpu_run_ctrl
   import cpu_run_ctrl_pkg::*;
#(
   parameter int unsigned IMEM_DEPTH = 128,
   parameter int unsigned DMEM_DEPTH = 128,
   parameter int          CYC_W      = 32
) (
   input  logic         clk,
   input  logic         rst,
   cpu_run_ctrl_if.slave host,
   output logic         cpu_arst_n,
   output logic         cpu_enable,
   output logic [63:0]  addr_ext,
   output logic         wen_ext,
   output logic         ren_ext,
   output logic [31:0]  wdata_ext,
   output logic [63:0]  addr_ext_2,
   output logic         wen_ext_2,
   output logic         ren_ext_2,
   output logic [63:0]  wdata_ext_2,
   input  logic [63:0]  rdata_ext_2
);

   state_e           state_q, state_d;
   logic [15:0]      idx_q, idx_d;
   logic [15:0]      ni_q, ni_d;
   logic [15:0]      nd_q, nd_d;
   logic [15:0]      no_q, no_d;
   logic [CYC_W-1:0] cyc_q, cyc_d;
   logic             arst_q, en_q;

   logic [15:0] ni_c, nd_c, no_c;
   logic        in_hs, out_hs, ld_hold;
   logic        hold_valid;
   logic [63:0] hold_data;

   assign ni_c = clamp16(host.n_instr, IMEM_DEPTH);
   assign nd_c = clamp16(host.n_din, DMEM_DEPTH);
   assign no_c = clamp16(host.n_dout, DMEM_DEPTH);

   assign in_hs  = host.in_valid && host.in_ready;
   assign out_hs = hold_valid && host.out_ready;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      ni_d    = ni_q;
      nd_d    = nd_q;
      no_d    = no_q;
      cyc_d   = cyc_q;
      ld_hold = 1'b0;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (host.start) begin
               ni_d    = ni_c;
               nd_d    = nd_c;
               no_d    = no_c;
               cyc_d   = host.run_cycles;
               idx_d   = RST_IDX;
               state_d = first_phase(S_LOAD_I, ni_c != 16'd0,
                                     nd_c != 16'd0,
                                     host.run_cycles != '0,
                                     no_c != 16'd0);
            end
         end
         S_LOAD_I: begin
            if (in_hs) begin
               if (idx_q == ni_q - 16'd1) begin
                  idx_d   = RST_IDX;
                  state_d = first_phase(S_LOAD_D, 1'b0,
                                        nd_q != 16'd0,
                                        cyc_q != '0,
                                        no_q != 16'd0);
               end else begin
                  idx_d = idx_q + 16'd1;
               end
            end
         end
         S_LOAD_D: begin
            if (in_hs) begin
               if (idx_q == nd_q - 16'd1) begin
                  idx_d   = RST_IDX;
                  state_d = first_phase(S_REL, 1'b0, 1'b0,
                                        cyc_q != '0,
                                        no_q != 16'd0);
               end else begin
                  idx_d = idx_q + 16'd1;
               end
            end
         end
         S_REL: state_d = S_RUN;
         S_RUN: begin
            cyc_d = cyc_q - CYC_W'(1);
            if (cyc_q == CYC_W'(1)) begin
               state_d = first_phase(S_DRAIN_RD, 1'b0, 1'b0,
                                     1'b0, no_q != 16'd0);
            end
         end
         S_DRAIN_RD: state_d = S_DRAIN_WAIT;
         S_DRAIN_WAIT: begin
            ld_hold = 1'b1;
            state_d = S_DRAIN_OUT;
         end
         S_DRAIN_OUT: begin
            if (out_hs) begin
               if (idx_q == no_q - 16'd1) begin
                  idx_d   = RST_IDX;
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 16'd1;
                  state_d = S_DRAIN_RD;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // CPU run signals are registered decodes of the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RST_STATE;
         idx_q   <= RST_IDX;
         ni_q    <= 16'd0;
         nd_q    <= 16'd0;
         no_q    <= 16'd0;
         cyc_q   <= '0;
         arst_q  <= RST_ARST_N;
         en_q    <= RST_ENABLE;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ni_q    <= ni_d;
         nd_q    <= nd_d;
         no_q    <= no_d;
         cyc_q   <= cyc_d;
         arst_q  <= !(state_d inside {S_IDLE, S_LOAD_I, S_LOAD_D});
         en_q    <= (state_d == S_RUN);
      end
   end

   out_hold_reg #(.W(64)) u_hold (
      .clk     (clk),
      .rst     (rst),
      .load_i  (ld_hold),
      .data_i  (rdata_ext_2),
      .ready_i (host.out_ready),
      .valid_o (hold_valid),
      .data_o  (hold_data)
   );

   assign host.in_ready  = state_q inside {S_LOAD_I, S_LOAD_D};
   assign host.out_valid = hold_valid;
   assign host.out_data  = hold_data;
   assign host.busy      = !(state_q inside {S_IDLE, S_DONE});
   assign host.done      = (state_q == S_DONE);

   assign wen_ext   = (state_q == S_LOAD_I) && host.in_valid;
   assign ren_ext   = 1'b0;
   assign addr_ext  = wen_ext ? 64'(idx_q) * 64'(IMEM_STRIDE) : RST_DATA;
   assign wdata_ext = wen_ext ? host.in_data[31:0] : 32'd0;

   assign wen_ext_2   = (state_q == S_LOAD_D) && host.in_valid;
   assign ren_ext_2   = (state_q == S_DRAIN_RD);
   assign addr_ext_2  = (wen_ext_2 || ren_ext_2) ?
                        64'(idx_q) * 64'(DMEM_STRIDE) : RST_DATA;
   assign wdata_ext_2 = wen_ext_2 ? host.in_data : RST_DATA;

   assign cpu_arst_n = arst_q;
   assign cpu_enable = en_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Randomized bench for cpu_run_ctrl with a behavioural dmem and a
// transaction-level model of the expected writes, run and drain.
module tb_cpu_run_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cpu_run_ctrl_if #(.CYC_W(32)) h ();

   logic        cpu_arst_n, cpu_enable;
   logic [63:0] addr_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;
   logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
   logic [31:0] wdata_ext;

   cpu_run_ctrl #(
      .IMEM_DEPTH(128), .DMEM_DEPTH(128), .CYC_W(32)
   ) dut (
      .clk(clk), .rst(rst), .host(h),
      .cpu_arst_n(cpu_arst_n), .cpu_enable(cpu_enable),
      .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
      .wdata_ext(wdata_ext),
      .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2),
      .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2),
      .rdata_ext_2(rdata_ext_2)
   );

   logic [63:0] mem [128];
   bit seeded = 1'b0;
   always @(posedge clk) begin
      if (!seeded) begin
         for (int i = 0; i < 128; i++) mem[i] <= {$urandom, $urandom};
         seeded <= 1'b1;
      end else if (wen_ext_2) begin
         mem[addr_ext_2[9:3]] <= wdata_ext_2;
      end
      if (ren_ext_2) rdata_ext_2 <= mem[addr_ext_2[9:3]];
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct { logic [63:0] a; logic [63:0] d; } wr_t;
   wr_t         iw_q[$];
   wr_t         dw_q[$];
   logic [63:0] ra_q[$];
   logic [63:0] od_q[$];
   int          en_cyc, en_rise;
   logic        en_prev, stall_prev;
   logic [63:0] stall_data;

   task automatic sample();
      if (wen_ext) iw_q.push_back('{addr_ext, 64'(wdata_ext)});
      if (wen_ext_2) dw_q.push_back('{addr_ext_2, wdata_ext_2});
      if (ren_ext_2) ra_q.push_back(addr_ext_2);
      if (h.out_valid && h.out_ready) od_q.push_back(h.out_data);
      if (cpu_enable) begin
         en_cyc++;
         if (!en_prev) en_rise++;
         chk("arst_during_en", 64'(cpu_arst_n), 64'd1);
      end
      en_prev = cpu_enable;
      if (stall_prev && h.out_valid)
         chk("out_stable", h.out_data, stall_data);
      stall_prev = h.out_valid && !h.out_ready;
      stall_data = h.out_data;
   endtask

   function automatic int clampi(input int v);
      return (v > 128) ? 128 : v;
   endfunction

   task automatic run_job(input string nm, input int ni, input int nd,
                          input int nr, input int no, input int vmode,
                          input int rmode, input bit poke);
      int          nic, ndc, noc, cyc, stall, wptr;
      bit          done_seen, v;
      logic [63:0] words[$];
      logic [63:0] expm[128];
      nic = clampi(ni);
      ndc = clampi(nd);
      noc = clampi(no);
      words.delete();
      for (int i = 0; i < nic + ndc; i++)
         words.push_back({$urandom, $urandom});
      for (int k = 0; k < 128; k++) expm[k] = mem[k];
      for (int j = 0; j < ndc; j++) expm[j] = words[nic + j];
      iw_q.delete(); dw_q.delete(); ra_q.delete(); od_q.delete();
      en_cyc = 0; en_rise = 0; en_prev = 1'b0; stall_prev = 1'b0;
      h.n_instr    = 16'(ni);
      h.n_din      = 16'(nd);
      h.n_dout     = 16'(no);
      h.run_cycles = 32'(nr);
      h.start      = 1'b1;
      @(posedge clk); #1;
      h.start = 1'b0;
      cyc = 0; stall = 0; wptr = 0; done_seen = 1'b0;
      while (cyc < 6000 && !done_seen) begin
         v = (wptr < words.size()) &&
             (vmode == 0 || (vmode == 1 && cyc % 2 == 0) ||
              (vmode == 2 && $urandom_range(1, 0) == 1));
         h.in_valid = v;
         h.in_data  = v ? words[wptr] : {$urandom, $urandom};
         h.out_ready = (rmode == 0) ? 1'b1 :
                       (rmode == 1) ? (stall >= 7) :
                       1'($urandom_range(1, 0));
         if (poke && cyc == 20) begin
            h.start  = 1'b1;
            h.n_dout = 16'd1;
         end else begin
            h.start = 1'b0;
         end
         @(negedge clk);
         if (cyc == 0) begin
            chk({nm, ":busy_t1"}, 64'(h.busy),
                64'((nic | ndc | nr | noc) != 0));
            chk({nm, ":arst_t1"}, 64'(cpu_arst_n),
                64'((nic | ndc) == 0));
         end
         if (poke && cyc == 20) chk({nm, ":poke_busy"}, 64'(h.busy), 64'd1);
         sample();
         if (h.in_valid && h.in_ready) wptr++;
         if (h.out_valid && !h.out_ready) stall++;
         else if (h.out_valid) stall = 0;
         if (h.done) done_seen = 1'b1;
         cyc++;
         @(posedge clk); #1;
      end
      h.in_valid = 1'b0;
      h.start    = 1'b0;
      chk({nm, ":done"}, 64'(done_seen), 64'd1);
      chk({nm, ":arst_done"}, 64'(cpu_arst_n), 64'd1);
      chk({nm, ":n_iw"}, 64'(iw_q.size()), 64'(nic));
      for (int i = 0; i < nic && i < iw_q.size(); i++) begin
         chk({nm, ":iw_addr"}, iw_q[i].a, 64'(4 * i));
         chk({nm, ":iw_data"}, iw_q[i].d, {32'd0, words[i][31:0]});
      end
      chk({nm, ":n_dw"}, 64'(dw_q.size()), 64'(ndc));
      for (int j = 0; j < ndc && j < dw_q.size(); j++) begin
         chk({nm, ":dw_addr"}, dw_q[j].a, 64'(8 * j));
         chk({nm, ":dw_data"}, dw_q[j].d, words[nic + j]);
      end
      chk({nm, ":en_cycles"}, 64'(en_cyc), 64'(nr));
      chk({nm, ":en_runs"}, 64'(en_rise), 64'(nr > 0));
      chk({nm, ":n_rd"}, 64'(ra_q.size()), 64'(noc));
      for (int k = 0; k < noc && k < ra_q.size(); k++)
         chk({nm, ":rd_addr"}, ra_q[k], 64'(8 * k));
      chk({nm, ":n_out"}, 64'(od_q.size()), 64'(noc));
      for (int k = 0; k < noc && k < od_q.size(); k++)
         chk({nm, ":out_data"}, od_q[k], expm[k]);
   endtask

   task automatic chk_reset(input string nm);
      chk({nm, ":busy"}, 64'(h.busy), 64'd0);
      chk({nm, ":done"}, 64'(h.done), 64'd0);
      chk({nm, ":in_ready"}, 64'(h.in_ready), 64'd0);
      chk({nm, ":out_valid"}, 64'(h.out_valid), 64'd0);
      chk({nm, ":arst_n"}, 64'(cpu_arst_n), 64'd0);
      chk({nm, ":enable"}, 64'(cpu_enable), 64'd0);
      chk({nm, ":strobes"},
          64'({wen_ext, ren_ext, wen_ext_2, ren_ext_2}), 64'd0);
      chk({nm, ":addr"}, addr_ext | addr_ext_2, 64'd0);
      chk({nm, ":wdata"}, 64'(wdata_ext) | wdata_ext_2, 64'd0);
   endtask

   initial begin
      int n, c;
      h.start = 1'b0; h.in_valid = 1'b0; h.in_data = '0;
      h.out_ready = 1'b0; h.n_instr = '0; h.n_din = '0;
      h.n_dout = '0; h.run_cycles = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset("reset");
      chk("reset:out_data", h.out_data, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      run_job("basic", 3, 2, 5, 2, 0, 0, 1'b0);
      run_job("toggle", 4, 0, 0, 1, 1, 0, 1'b0);
      run_job("stall", 1, 3, 2, 3, 0, 1, 1'b0);
      run_job("zero", 0, 0, 0, 0, 0, 0, 1'b0);

      h.n_instr = '0; h.n_din = '0; h.n_dout = '0;
      h.run_cycles = 32'd10; h.start = 1'b1;
      @(posedge clk); #1;
      h.start = 1'b0;
      n = 0; c = 0;
      while (n < 2 && c < 50) begin
         @(negedge clk);
         if (cpu_enable) n++;
         c++;
         @(posedge clk); #1;
      end
      chk("midrst:reach", 64'(n), 64'd2);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst:en_before", 64'(cpu_enable), 64'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk_reset("midrst");
      @(posedge clk); #1;

      run_job("after_rst", 2, 2, 3, 2, 2, 2, 1'b0);
      run_job("clamp", 0, 0, 1, 300, 0, 0, 1'b1);
      for (int r = 0; r < 4; r++)
         run_job("rand", $urandom_range(6, 0), $urandom_range(6, 0),
                 $urandom_range(8, 0), $urandom_range(6, 0), 2, 2, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Host-side run controller for the pipelined RISC-V `cpu` top. It owns both external memory ports and the CPU run signals. On `start` it streams a program into instruction memory and initial data into data memory, releases the CPU reset, and enables the core for a programmed number of cycles. It then streams a programmed range of data memory back to the host. It sits between the testbench/host link and `cpu`, replacing ad-hoc testbench poking of the `*_ext` ports.

## Interface
- `IMEM_DEPTH`, default 128: instruction-memory words; `n_instr` is clamped to this.
- `DMEM_DEPTH`, default 128: data-memory words; `n_din` and `n_dout` are clamped to this.
- `CYC_W`, default 32: width of the run-cycle counter.
- `clk`  in  1  single clock; every register is clocked on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  single-cycle pulse; sampled only in IDLE or DONE.
- `n_instr`, `n_din`, `n_dout`  in  16 each  word counts; captured on an accepted `start`.
- `run_cycles`  in  CYC_W  number of enabled CPU cycles; captured on an accepted `start`.
- `in_valid` in 1, `in_ready` out 1, `in_data` in 64  load stream.
  - Instruction words use `in_data[31:0]`.
  - Data words use all 64 bits.
- `out_valid` out 1, `out_ready` in 1, `out_data` out 64  drain stream.
- `cpu_arst_n`  out  1  drives `cpu.arst_n`; registered.
- `cpu_enable`  out  1  drives `cpu.enable`; registered.
- `addr_ext` out 64, `wen_ext` out 1, `ren_ext` out 1, `wdata_ext` out 32  instruction-memory external port.
- `addr_ext_2` out 64, `wen_ext_2` out 1, `ren_ext_2` out 1, `wdata_ext_2` out 64, `rdata_ext_2` in 64  data-memory external port.
- `busy`  out  1  high in every state except IDLE and DONE.
- `done`  out  1  high in DONE.

## Operation
- States are IDLE, LOAD_I, LOAD_D, REL, RUN, DRAIN_RD, DRAIN_WAIT, DRAIN_OUT, DONE.
- An accepted `start` captures the configuration and enters LOAD_I.
  - Zero-length phases are skipped in order: LOAD_I, then LOAD_D, then REL/RUN (skipped when `run_cycles`=0), then the drain states.
  - If every phase is skipped, the block goes directly to DONE.
- LOAD_I: `in_ready`=1.
  - On each handshake: `wen_ext`=1, `addr_ext`=4·idx, `wdata_ext`=`in_data[31:0]`, then idx increments.
  - After the last word, go to LOAD_D.
- LOAD_D: `in_ready`=1.
  - On each handshake: `wen_ext_2`=1, `addr_ext_2`=8·idx, `wdata_ext_2`=`in_data`.
- `in_ready` is 0 in all other states. Write strobes are combinational in `in_valid && in_ready`.
- REL lasts exactly one cycle: `cpu_arst_n` rises, `cpu_enable`=0.
- RUN: `cpu_enable`=1 for exactly `run_cycles` consecutive cycles, then 0.
- Drain, per word idx:
  - DRAIN_RD: `ren_ext_2`=1, `addr_ext_2`=8·idx.
  - DRAIN_WAIT: capture `rdata_ext_2` (data memory read latency is 1 cycle).
  - DRAIN_OUT: `out_valid`=1 with `out_data` stable until `out_ready`. On the handshake, take the next idx or go to DONE.
- `cpu_arst_n` is 0 in IDLE, LOAD_I and LOAD_D, and 1 from REL through DONE, so DONE preserves CPU state for inspection.
- `start` in DONE re-enters LOAD_I and drives `cpu_arst_n` low again.
- `start` in any busy state is ignored.
- Counts above the memory depth are clamped to the depth.

## Timing
- Reset values: state=IDLE; `cpu_arst_n`=0; `cpu_enable`=0; every strobe, `in_ready`, `out_valid`, `busy` and `done`=0; addresses and data=0.
- `start` at cycle t puts the block in the first non-skipped state at t+1, with `busy`=1 at t+1.
- Load throughput is 1 word/cycle while `in_valid` is held. Bubbles in `in_valid` stall the index.
- `cpu_enable` goes high the cycle after REL and is high for exactly `run_cycles` cycles.
- Drain costs 3 cycles/word minimum; `out_ready` low stretches DRAIN_OUT.
- `rst` asserted in any state returns the block to reset values on the next edge. A partial load is abandoned; there is no resume.
- Index counters are 16-bit and never wrap, because of the clamp.

## Structure
- Package `cpu_run_ctrl_pkg` holds:
  - the state enumeration;
  - `IMEM_STRIDE`=4 and `DMEM_STRIDE`=8;
  - the reset-value constants.
- One sub-module, `out_hold_reg`: a 64-bit valid/ready holding register for the drain stream.
- Everything else lives in one FSM with two counters: the word index and the run cycles.

## Test plan
- `n_instr`=3, `n_din`=2, `run_cycles`=5, `n_dout`=2, continuous valid:
  - `wen_ext` on addresses 0, 4, 8;
  - `wen_ext_2` on addresses 0, 8;
  - `cpu_enable` high for exactly 5 cycles;
  - `out_data` equals the dmem words at 0 and 8; `done`=1.
- `in_valid` toggled 1010… during a 4-word LOAD_I: exactly 4 writes at 0, 4, 8, 12 and no duplicate addresses.
- `out_ready` low for 7 cycles in DRAIN_OUT: `out_data` stable and no extra `ren_ext_2` pulses.
- `n_instr`=0, `n_din`=0, `run_cycles`=0, `n_dout`=0: IDLE→DONE in 1 cycle with no strobes.
- `rst` mid-RUN at cycle 3 of 10: the next edge gives `cpu_enable`=0, `cpu_arst_n`=0, IDLE; a later `start` runs cleanly.
- `n_dout`=300 with `DMEM_DEPTH`=128: exactly 128 output words; a `start` pulse while busy is ignored.
